// File: rtl/load_store_unit_pkg.sv
// Shared RV32I types for the memory stage: funct3 encodings for loads and
// stores, the load/store unit state encoding and an access-size helper.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } access_size_t;

  // Width is carried in funct3[1:0]; the reserved encodings (011, 110, 111)
  // fall through to a full word access.
  function automatic access_size_t access_size(input logic [2:0] funct3);
    access_size_t size;
    case (funct3[1:0])
      LB[1:0]: size = SIZE_BYTE;
      LH[1:0]: size = SIZE_HALF;
      default: size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit. The store side works on the
// live request (it is latched by the parent on acceptance); the load side
// works on the latched funct3/offset and the raw memory read data.
module lsu_align
  import rv32i_types::*;
(
  input  logic [2:0]      i_req_funct3,
  input  logic [1:0]      i_req_off,
  input  logic [XLEN-1:0] i_store_data,
  output logic [3:0]      o_wmask,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_misalign,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_load_data
);

  access_size_t w_req_size;
  access_size_t w_ld_size;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;

  // Store mask/data shifting and alignment check for the incoming request.
  always_comb begin
    w_req_size = access_size(i_req_funct3);
    o_wmask    = 4'b0000;
    o_wdata    = '0;
    o_misalign = 1'b0;
    case (w_req_size)
      SIZE_BYTE: begin
        o_wmask = 4'b0001 << i_req_off;
        o_wdata = i_store_data << {i_req_off, 3'b000};
      end
      SIZE_HALF: begin
        o_wmask    = 4'b0011 << i_req_off;
        o_wdata    = i_store_data << {i_req_off, 3'b000};
        o_misalign = i_req_off[0];
      end
      default: begin
        o_wmask    = 4'b1111;
        o_wdata    = i_store_data;
        o_misalign = |i_req_off;
      end
    endcase
  end

  // Load lane selection and sign/zero extension; funct3[2] marks the unsigned forms.
  always_comb begin
    w_ld_size   = access_size(i_ld_funct3);
    w_byte      = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_half      = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
    o_load_data = i_rdata;
    case (w_ld_size)
      SIZE_BYTE: begin
        if (i_ld_funct3[2]) o_load_data = {24'b0, w_byte};
        else                o_load_data = {{24{w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        if (i_ld_funct3[2]) o_load_data = {16'b0, w_half};
        else                o_load_data = {{16{w_half[15]}}, w_half};
      end
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage data-memory controller: turns one load or store into a single
// word-aligned transaction, stalls the pipeline until the memory responds and
// returns the extended load result. Misaligned requests are rejected on the spot.
module load_store_unit
  import rv32i_types::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_dmem_address,
  output logic            o_dmem_read,
  output logic            o_dmem_write,
  output logic [3:0]      o_dmem_wmask,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic [XLEN-1:0] i_dmem_rdata,
  input  logic            i_dmem_resp
);

  lsu_state_t      r_state;
  logic            r_dmem_read;
  logic            r_dmem_write;
  logic [3:0]      r_wmask;
  logic [XLEN-1:0] r_address;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic            r_done;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_off;

  logic            w_access;
  logic            w_misalign_term;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  assign w_access = i_req_valid & (i_mem_read | i_mem_write);

  lsu_align u_align (
    .i_req_funct3 (i_funct3),
    .i_req_off    (i_addr[1:0]),
    .i_store_data (i_store_data),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_misalign   (w_misalign_term),
    .i_ld_funct3  (r_ld_funct3),
    .i_ld_off     (r_ld_off),
    .i_rdata      (i_dmem_rdata),
    .o_load_data  (w_load_data)
  );

  // A request is only evaluated in IDLE; the reset gate keeps the pulse quiet while held in reset.
  assign o_misalign = i_rst_n & (r_state == IDLE) & w_access & w_misalign_term;

  assign o_stall        = w_access & ~r_done & ~o_misalign;
  assign o_done         = r_done;
  assign o_load_data    = r_load_data;
  assign o_dmem_address = r_address;
  assign o_dmem_read    = r_dmem_read;
  assign o_dmem_write   = r_dmem_write;
  assign o_dmem_wmask   = r_wmask;
  assign o_dmem_wdata   = r_wdata;

  // Access FSM: latch the request in IDLE, hold the strobe in WAIT, pulse done in DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_dmem_read  <= 1'b0;
      r_dmem_write <= 1'b0;
      r_wmask      <= 4'b0000;
      r_address    <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_done       <= 1'b0;
      r_ld_funct3  <= 3'b000;
      r_ld_off     <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_access && !w_misalign_term) begin
            r_address   <= {i_addr[XLEN-1:2], 2'b00};
            r_ld_funct3 <= i_funct3;
            r_ld_off    <= i_addr[1:0];
            if (i_mem_read) begin
              r_dmem_read <= 1'b1;
              r_wmask     <= 4'b0000;
              r_wdata     <= '0;
            end else begin
              r_dmem_write <= 1'b1;
              r_wmask      <= w_wmask;
              r_wdata      <= w_wdata;
            end
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_dmem_resp) begin
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            if (r_dmem_read) r_load_data <= w_load_data;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of load/store vectors with
// hand-computed expectations, a scoreboard queue popped on done, and hand-written
// sequences for long waits and reset in the middle of an access.
module tb_load_store_unit;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    bit          expMis;
    logic [31:0] expAddr;
    logic [3:0]  expMask;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        stall;
  logic        done;
  logic [31:0] loadData;
  logic        misalign;
  logic [31:0] dmemAddress;
  logic        dmemRead;
  logic        dmemWrite;
  logic [3:0]  dmemWmask;
  logic [31:0] dmemWdata;
  logic [31:0] dmemRdata;
  logic        dmemResp;

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t expQ[$];
  vec_t vecs[20];

  load_store_unit dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_req_valid    (reqValid),
    .i_mem_read     (memRead),
    .i_mem_write    (memWrite),
    .i_funct3       (funct3),
    .i_addr         (addr),
    .i_store_data   (storeData),
    .o_stall        (stall),
    .o_done         (done),
    .o_load_data    (loadData),
    .o_misalign     (misalign),
    .o_dmem_address (dmemAddress),
    .o_dmem_read    (dmemRead),
    .o_dmem_write   (dmemWrite),
    .o_dmem_wmask   (dmemWmask),
    .o_dmem_wdata   (dmemWdata),
    .i_dmem_rdata   (dmemRdata),
    .i_dmem_resp    (dmemResp)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdat, input int dly, input bit mis,
                                 input logic [31:0] eAddr, input logic [3:0] eMask,
                                 input logic [31:0] eWdata, input logic [31:0] eLoad);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdat;
    v.delay = dly; v.expMis = mis; v.expAddr = eAddr; v.expMask = eMask;
    v.expWdata = eWdata; v.expLoad = eLoad;
    return v;
  endfunction

  // Drives one request, services it like a memory with the vector's response delay,
  // and checks strobes, stability, latency and the scoreboarded result.
  task automatic applyStimulus(input vec_t v);
    int  waited;
    bit  seenDone;
    vec_t e;
    @(negedge clk);
    reqValid  = 1'b1;
    memRead   = v.rd;
    memWrite  = v.wr;
    funct3    = v.f3;
    addr      = v.addr;
    storeData = v.sdata;
    dmemResp  = 1'b0;
    #1;
    if (v.expMis) begin
      checkOutput("misalign_pulse", {31'b0, misalign}, 32'd1);
      checkOutput("misalign_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("misalign_no_read", {31'b0, dmemRead}, 32'd0);
      checkOutput("misalign_no_write", {31'b0, dmemWrite}, 32'd0);
      checkOutput("misalign_no_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      reqValid = 1'b0;
    end else begin
      checkOutput("accept_misalign", {31'b0, misalign}, 32'd0);
      checkOutput("accept_stall", {31'b0, stall}, 32'd1);
      expQ.push_back(v);
      @(posedge clk);
      #1;
      addr      = ~v.addr;
      storeData = ~v.sdata;
      funct3    = v.f3 ^ 3'b001;
      waited    = 0;
      seenDone  = 1'b0;
      for (int c = 0; c < 40 && !seenDone; c++) begin
        @(negedge clk);
        if (done) begin
          seenDone = 1'b1;
        end else begin
          checkOutput("wait_read", {31'b0, dmemRead}, {31'b0, v.rd});
          checkOutput("wait_write", {31'b0, dmemWrite}, {31'b0, v.wr & ~v.rd});
          checkOutput("wait_address", dmemAddress, v.expAddr);
          checkOutput("wait_wmask", {28'b0, dmemWmask}, {28'b0, v.expMask});
          checkOutput("wait_wdata", dmemWdata, v.expWdata);
          checkOutput("wait_stall", {31'b0, stall}, 32'd1);
          if (waited == v.delay) begin
            dmemResp  = 1'b1;
            dmemRdata = v.rdata;
          end else begin
            dmemResp  = 1'b0;
            dmemRdata = $urandom;
          end
          waited++;
        end
      end
      dmemResp = 1'b0;
      if (!seenDone) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL done_timeout: got no done after 40 cycles required done after %0d", v.delay + 1);
      end else begin
        checkOutput("latency", waited, v.delay + 1);
        checkOutput("done_stall", {31'b0, stall}, 32'd0);
        checkOutput("done_strobes", {30'b0, dmemRead, dmemWrite}, 32'd0);
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL scoreboard_empty: got done with empty queue required queued entry");
        end else begin
          e = expQ.pop_front();
          if (e.rd) checkOutput("load_data", loadData, e.expLoad);
        end
      end
      @(negedge clk);
      reqValid = 1'b0;
      #1;
      checkOutput("done_once", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = mkVec(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0);
    vecs[1]  = mkVec(1, 0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FF80);
    vecs[2]  = mkVec(1, 0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_0080);
    vecs[3]  = mkVec(1, 0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001);
    vecs[4]  = mkVec(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001);
    vecs[5]  = mkVec(1, 0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[6]  = mkVec(0, 1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 5, 0, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[7]  = mkVec(0, 1, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 32'h0, 0, 0, 32'h0000_5000, 4'b1100, 32'hABCD_0000, 32'h0);
    vecs[8]  = mkVec(0, 1, 3'b001, 32'h0000_5001, 32'h1234_ABCD, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[9]  = mkVec(1, 0, 3'b010, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 2, 0, 32'h0000_6004, 4'b0000, 32'h0, 32'hCAFE_F00D);
    vecs[10] = mkVec(1, 0, 3'b000, 32'h0000_7000, 32'h0, 32'h1234_567F, 0, 0, 32'h0000_7000, 4'b0000, 32'h0, 32'h0000_007F);
    vecs[11] = mkVec(1, 0, 3'b101, 32'h0000_7000, 32'h0, 32'hFFFF_8765, 0, 0, 32'h0000_7000, 4'b0000, 32'h0, 32'h0000_8765);
    vecs[12] = mkVec(1, 0, 3'b001, 32'h0000_7000, 32'h0, 32'hFFFF_8765, 0, 0, 32'h0000_7000, 4'b0000, 32'h0, 32'hFFFF_8765);
    vecs[13] = mkVec(0, 1, 3'b000, 32'h0000_8001, 32'h0000_00C3, 32'h0, 0, 0, 32'h0000_8000, 4'b0010, 32'h0000_C300, 32'h0);
    vecs[14] = mkVec(1, 1, 3'b010, 32'h0000_9000, 32'h5555_5555, 32'h0102_0304, 1, 0, 32'h0000_9000, 4'b0000, 32'h0, 32'h0102_0304);
    vecs[15] = mkVec(0, 1, 3'b011, 32'h0000_A000, 32'h55AA_55AA, 32'h0, 0, 0, 32'h0000_A000, 4'b1111, 32'h55AA_55AA, 32'h0);
    vecs[16] = mkVec(1, 0, 3'b111, 32'h0000_A004, 32'h0, 32'h89AB_CDEF, 0, 0, 32'h0000_A004, 4'b0000, 32'h0, 32'h89AB_CDEF);
    vecs[17] = mkVec(1, 0, 3'b110, 32'h0000_A002, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0);
    vecs[18] = mkVec(1, 0, 3'b100, 32'h0000_B003, 32'h0, 32'h9F00_0000, 3, 0, 32'h0000_B000, 4'b0000, 32'h0, 32'h0000_009F);
    vecs[19] = mkVec(1, 0, 3'b000, 32'h0000_B003, 32'h0, 32'h9F00_0000, 0, 0, 32'h0000_B000, 4'b0000, 32'h0, 32'hFFFF_FF9F);

    // Reset with a misaligned request already on the inputs: every output must be quiet.
    rstN      = 1'b0;
    reqValid  = 1'b1;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_3002;
    storeData = 32'h0;
    dmemRdata = 32'h0;
    dmemResp  = 1'b0;
    #12;
    checkOutput("reset_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("reset_strobes", {30'b0, dmemRead, dmemWrite}, 32'd0);
    checkOutput("reset_wmask", {28'b0, dmemWmask}, 32'd0);
    checkOutput("reset_address", dmemAddress, 32'd0);
    checkOutput("reset_wdata", dmemWdata, 32'd0);
    checkOutput("reset_load_data", loadData, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    rstN     = 1'b1;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    // Reset in the middle of WAIT: strobes drop at once and a late response is discarded.
    @(negedge clk);
    reqValid  = 1'b1;
    memRead   = 1'b0;
    memWrite  = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_C000;
    storeData = 32'h0BAD_F00D;
    @(negedge clk);
    checkOutput("midreset_write_before", {31'b0, dmemWrite}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_write_after", {31'b0, dmemWrite}, 32'd0);
    checkOutput("midreset_wmask", {28'b0, dmemWmask}, 32'd0);
    checkOutput("midreset_address", dmemAddress, 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    rstN     = 1'b1;
    dmemResp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("late_resp_no_done", {31'b0, done}, 32'd0);
      checkOutput("late_resp_no_strobe", {30'b0, dmemRead, dmemWrite}, 32'd0);
    end
    dmemResp = 1'b0;

    // After the disturbed access the unit still serves a normal load.
    applyStimulus(vecs[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
